// File: rtl/apb_sram_ctrl.sv
// APB slave bridging single-beat transfers onto a synchronous single-port SRAM.
// Writes take 2 cycles; reads take 3 cycles because the SRAM has a registered output.
module apb_sram_ctrl #(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_BITS+1:0]    paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [ADDR_BITS-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout,
    output logic [7:0]              err_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RDATA = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_BITS-1:0]    addr_nxt;
    logic [DATA_WIDTH-1:0]   din_nxt;
    logic [CNT_W-1:0]        err_cnt_nxt;
    logic [ADDR_BITS-1:0]    word_c;
    logic                    bad_c;

    assign word_c = paddr[ADDR_BITS+1:2];
    assign bad_c  = (paddr[1:0] != 2'b00) || (32'(word_c) >= MEM_DEPTH);

    // State and capture registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            sram_addr <= '0;
            sram_din  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            sram_addr <= addr_nxt;
            sram_din  <= din_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

    // Next state; transfer direction is carried by the WR/RD state itself
    always_comb begin
        state_nxt   = state;
        addr_nxt    = sram_addr;
        din_nxt     = sram_din;
        err_cnt_nxt = err_cnt;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    addr_nxt = word_c;
                    din_nxt  = pwdata;
                    if (bad_c) begin
                        state_nxt = ERR;
                    end else if (pwrite) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            WR:    state_nxt = IDLE;
            RD:    state_nxt = psel ? RDATA : IDLE;
            RDATA: state_nxt = IDLE;
            ERR: begin
                state_nxt = IDLE;
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt_nxt = err_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only; reset kills any in-flight strobe
    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        sram_en = 1'b0;
        sram_we = 1'b0;
        prdata  = '0;
        if (rstn) begin
            case (state)
                WR: begin
                    sram_en = 1'b1;
                    sram_we = 1'b1;
                    pready  = 1'b1;
                end
                RD: begin
                    sram_en = 1'b1;
                end
                RDATA: begin
                    pready = 1'b1;
                    prdata = sram_dout;
                end
                ERR: begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Self-checking bench for apb_sram_ctrl: behavioural SRAM, response scoreboard,
// table-driven transfers and hand-written reset/abort/noise sequences.
module tb_apb_sram_ctrl;

    localparam int unsigned MEM_DEPTH = 512;
    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = ADDR_BITS + 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [DW-1:0]     sram_din;
    logic [DW-1:0]     sram_dout;
    logic [7:0]        err_cnt;

    apb_sram_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .sram_en  (sram_en),
        .sram_we  (sram_we),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM with registered read data
    logic [DW-1:0] mem [0:(1<<ADDR_BITS)-1];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout      <= mem[sram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    // Response monitor: every pready must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rstn) begin
            if (pready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pready: got pready=1 expected 0 at %0t", $time);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("resp_pslverr", 32'(pslverr), 32'(e_mon.err));
                    chk("resp_prdata", prdata, e_mon.rdata);
                end
            end else begin
                chk("quiet_prdata", prdata, 32'h0);
                chk("quiet_pslverr", 32'(pslverr), 32'h0);
            end
        end else begin
            chk("rst_sram_en", 32'(sram_en), 32'h0);
            chk("rst_pready", 32'(pready), 32'h0);
        end
    end

    // One APB transfer, starting just after a rising edge; leaves bus idle-ready for back-to-back use
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        int   cyc;
        int   want;
        bit   done;
        e.err   = exp_err;
        e.rdata = (exp_err || wr) ? 32'h0 : exp_rd;
        exp_q.push_back(e);
        want    = (exp_err || wr) ? 2 : 3;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        cyc     = 1;
        done    = 1'b0;
        @(negedge clk);
        if (exp_err) chk("err_no_sram_en", 32'(sram_en), 32'h0);
        @(posedge clk);
        #1 penable = 1'b1;
        while (!done && cyc < 8) begin
            cyc++;
            @(negedge clk);
            if (exp_err) chk("err_no_sram_en", 32'(sram_en), 32'h0);
            if (!exp_err && cyc == 2) begin
                chk("acc_sram_en", 32'(sram_en), 32'h1);
                chk("acc_sram_we", 32'(sram_we), 32'(wr));
                chk("acc_sram_addr", 32'(sram_addr), 32'(addr[AW-1:2]));
                if (wr) chk("acc_sram_din", sram_din, wdata);
            end
            if (pready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("xfer_cycles", 32'(cyc), 32'(want));
        if (!done) exp_q.delete();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          err;
        logic [31:0]   rdata;
    } vec_t;
    vec_t tbl[11];

    int exp_errs;
    int t0;

    initial begin
        tbl[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 12'h006, 32'h0,        1'b1, 32'h0};
        tbl[3]  = '{1'b1, 12'h000, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 12'h800, 32'hBAD0BAD0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 12'h000, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[6]  = '{1'b0, 12'hFFC, 32'h0,        1'b1, 32'h0};
        tbl[7]  = '{1'b1, 12'h7FC, 32'h5A5A1234, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 12'h7FC, 32'h0,        1'b0, 32'h5A5A1234};
        tbl[9]  = '{1'b1, 12'h013, 32'h11111111, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 12'h802, 32'h0,        1'b1, 32'h0};

        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_sram_din", sram_din, 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;

        exp_errs = 0;
        for (int i = 0; i < 11; i++) begin
            apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata);
            if (tbl[i].err) exp_errs++;
            chk("tbl_err_cnt", 32'(err_cnt), 32'(exp_errs));
        end

        // Back-to-back: 8 writes then 8 reads with no idle cycles
        t0 = cycle_cnt;
        for (int i = 0; i < 8; i++) apb_xfer(1'b1, AW'(i * 4), 32'(i), 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) apb_xfer(1'b0, AW'(i * 4), 32'h0, 1'b0, 32'(i));
        chk("b2b_total_cycles", 32'(cycle_cnt - t0), 32'd40);

        // Error counter saturation
        for (int i = 0; i < 300; i++) apb_xfer(1'b1, 12'h800, 32'hFFFFFFFF, 1'b1, 32'h0);
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
        apb_xfer(1'b0, 12'h000, 32'h0, 1'b0, 32'h0);

        // Reset during the WR cycle of a write to word 3
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h12345678;
        @(posedge clk);
        #1 penable = 1'b1; rstn = 1'b0;
        @(negedge clk);
        chk("rstwr_sram_en", 32'(sram_en), 32'h0);
        chk("rstwr_sram_we", 32'(sram_we), 32'h0);
        chk("rstwr_pready", 32'(pready), 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1; psel = 1'b0; penable = 1'b0;
        apb_xfer(1'b0, 12'h00C, 32'h0, 1'b0, 32'd3);
        chk("rstwr_err_cnt", 32'(err_cnt), 32'h0);

        // Read aborted by dropping psel in RD
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h014;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_rd_pready", 32'(pready), 32'h0);
        chk("abort_rd_sram_en", 32'(sram_en), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_next_pready", 32'(pready), 32'h0);
        chk("abort_next_sram_en", 32'(sram_en), 32'h0);
        @(posedge clk);
        #1;
        apb_xfer(1'b0, 12'h014, 32'h0, 1'b0, 32'd5);

        // Access-phase pattern presented in IDLE must be ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hDEAD0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("noise_sram_en", 32'(sram_en), 32'h0);
            chk("noise_pready", 32'(pready), 32'h0);
            @(posedge clk);
        end
        #1;
        chk("noise_addr_hold", 32'(sram_addr), 32'd5);
        psel = 1'b0; penable = 1'b0;
        apb_xfer(1'b0, 12'h010, 32'h0, 1'b0, 32'd4);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_sram_ctrl.md
APB_SRAM_CTRL -- requirements
Module: apb_sram_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  MEM_DEPTH   1024  number of SRAM words.
  ADDR_BITS   10    SRAM word-address width.
  DATA_WIDTH  32    data width.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk        in   1              single clock; all state updates on rising edge.
  rstn       in   1              reset, synchronous, active-low.
  psel       in   1              APB select.
  penable    in   1              APB enable.
  pwrite     in   1              1 = write, 0 = read.
  paddr      in   ADDR_BITS+2    APB byte address.
  pwdata     in   DATA_WIDTH     APB write data.
  prdata     out  DATA_WIDTH     APB read data.
  pready     out  1              APB transfer complete.
  pslverr    out  1              APB error response.
  sram_en    out  1              SRAM enable.
  sram_we    out  1              SRAM write enable.
  sram_addr  out  ADDR_BITS      SRAM word address.
  sram_din   out  DATA_WIDTH     SRAM write data.
  sram_dout  in   DATA_WIDTH     SRAM read data; registered; valid the cycle after an enabled read edge.
  err_cnt    out  8              saturating count of error responses.

Function
REQ-003 Block SHALL implement an FSM with states IDLE, WR, RD, RDATA and ERR.
REQ-004 In IDLE with psel=1 and penable=0 (setup phase), the block SHALL latch pwrite, paddr[ADDR_BITS+1:2] into sram_addr, and pwdata into sram_din.
REQ-005 On that setup phase the block SHALL decode the request.
  - Error if paddr[1:0]!=0 or paddr[ADDR_BITS+1:2]>=MEM_DEPTH: next state ERR.
  - Else write: next state WR.
  - Else read: next state RD.
REQ-006 IDLE SHALL ignore psel=1 with penable=1 and SHALL remain in IDLE.
REQ-007 Write transfer timing (0 wait states):
  - WR state: sram_en=1, sram_we=1, pready=1, pslverr=0.
  - The SRAM write commits at the edge ending WR.
  - Next state IDLE.
REQ-008 Read transfer timing (1 wait state):
  - RD state: sram_en=1, sram_we=0, pready=0.
  - Next state RDATA.
  - RDATA state: sram_en=0, pready=1, prdata=sram_dout.
  - Next state IDLE.
REQ-009 ERR state: pready=1, pslverr=1, sram_en=0, prdata=0; next state IDLE; err_cnt increments by 1 and saturates at 255.
REQ-010 Outside RDATA, prdata SHALL be 0; outside ERR, pslverr SHALL be 0; pready SHALL be 0 in IDLE and RD.
REQ-011 pready, pslverr, sram_en and sram_we SHALL be decoded from the state register only; there SHALL be no combinational path from APB inputs to them.
REQ-012 sram_en and sram_we SHALL be forced to 0 in any cycle where rstn=0.
REQ-013 sram_addr and sram_din SHALL hold their values outside the setup-phase capture.
REQ-014 Abort: if psel=0 in RD, the block SHALL return to IDLE at the next edge with no RDATA response.
  - The WR and RDATA states themselves SHALL always complete in one cycle regardless of psel.
REQ-015 Back-to-back transfers: a setup phase in the first IDLE cycle after completion SHALL be accepted, giving 2 cycles per write and 3 cycles per read.
REQ-016 No SRAM access SHALL be issued for an error transfer.

Reset
REQ-017 While rstn=0 at a rising edge, the block SHALL set the following values.
  - State: IDLE.
  - sram_addr=0, sram_din=0, err_cnt=0.
  - All other outputs are decoded from IDLE: pready=0, pslverr=0, prdata=0, sram_en=0, sram_we=0.
REQ-018 Reset mid-transfer SHALL abort the transfer with no pready pulse.
  - A write whose WR cycle coincides with rstn=0 SHALL NOT reach the SRAM (per REQ-012).
REQ-019 SRAM contents are not reset; the block SHALL NOT initialise memory.

Verification
REQ-020 Write then read:
  - Stimulus: write 0xDEADBEEF to paddr 0x010, then read paddr 0x010.
  - Write: sram_en=sram_we=1 with sram_addr=4 in WR; pready in 2nd cycle.
  - Read: pready in 3rd cycle with prdata=0xDEADBEEF, pslverr=0.
REQ-021 Misaligned access:
  - Stimulus: read paddr 0x006.
  - Response: ERR; pready=pslverr=1 in 2nd cycle; sram_en never asserted; err_cnt 0->1.
REQ-022 Out of range (MEM_DEPTH=512):
  - Stimulus: write paddr 0x800 (word 512).
  - Response: pslverr=1; SRAM word 0 unchanged.
  - After 300 such errors: err_cnt=255.
REQ-023 Back-to-back:
  - Stimulus: writes to words 0..7 with data = index, then reads of words 0..7, all with no idle gaps.
  - Response: every read returns its index; writes complete every 2 cycles, reads every 3 cycles.
REQ-024 Reset and abort:
  - Stimulus A: rstn=0 during the WR cycle of a write of 0x12345678 to word 3.
  - Response A: sram_en=0; word 3 keeps its prior value; FSM is in IDLE next cycle.
  - Stimulus B: psel dropped in RD.
  - Response B: no pready; FSM in IDLE next cycle.
REQ-025 Protocol noise:
  - Stimulus: psel=1, penable=1 presented while in IDLE.
  - Response: no transition; no SRAM access.
